zion_riscv_isa_lib_bits_ex_arbiter: RTL and testbench

Round-robin arbiter and result stage sharing one bit-operation (AND/OR/XOR) execution datapath among `REQ_NUM` issue ports. It converts each port's 2-bit op code into the one-hot `andEn`/`orEn`/`xorEn` controls, which guarantees the "only one enable active" rule by construction. It registers the result with its requester ID behind a valid/ready handshake. It sits between the issue/decode ports and the write-back arbiter.

---
 rtl/zion_riscv_isa_lib_bits_ex_arbiter.sv | 150 +++++++++++++++
 tb/tb_zion_riscv_isa_lib_bits_ex_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/zion_riscv_isa_lib_bits_ex_arbiter.sv
// Round-robin arbiter feeding a shared AND/OR/XOR datapath.
// The result is registered together with the requester ID behind a valid/ready handshake.
module zion_riscv_isa_lib_bits_ex_arbiter #(
    parameter  int RV64      = 0,
    parameter  int REQ_NUM   = 2,
    localparam int CPU_WIDTH = 32 * (RV64 + 1),
    localparam int ID_W      = $clog2(REQ_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_NUM-1:0]           iReqVld,
    output logic [REQ_NUM-1:0]           oReqRdy,
    input  logic [2*REQ_NUM-1:0]         iReqOp,
    input  logic [CPU_WIDTH*REQ_NUM-1:0] iReqS1,
    input  logic [CPU_WIDTH*REQ_NUM-1:0] iReqS2,
    output logic                         oRsltVld,
    input  logic                         iRsltRdy,
    output logic [CPU_WIDTH-1:0]         oRslt,
    output logic [ID_W-1:0]              oRsltId,
    output logic                         oRsltErr,
    output logic                         oBusy
);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 vld_q, vld_d;
    logic [CPU_WIDTH-1:0] rslt_q, rslt_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 err_q, err_d;

    logic                 stage_free;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [REQ_NUM-1:0]   win_oh;
    logic                 grant;
    logic [1:0]           sel_op;
    logic [CPU_WIDTH-1:0] sel_s1, sel_s2;
    logic                 and_en, or_en, xor_en;
    logic [CPU_WIDTH-1:0] alu_res;

    assign stage_free = !vld_q | iRsltRdy;

    // Scan ports starting at ptr_q, wrapping modulo REQ_NUM.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!win_found && iReqVld[k] &&
                    (k == (int'(ptr_q) + i) % REQ_NUM)) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(k);
                end
            end
        end
    end

    assign grant = win_found & stage_free & !rst;

    always_comb begin
        win_oh = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            win_oh[k] = (win_id == ID_W'(k));
        end
    end

    assign oReqRdy = grant ? win_oh : '0;

    always_comb begin
        sel_op = '0;
        sel_s1 = '0;
        sel_s2 = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            sel_op = sel_op | ({2{win_oh[k]}} & iReqOp[2*k +: 2]);
            sel_s1 = sel_s1 | ({CPU_WIDTH{win_oh[k]}} & iReqS1[CPU_WIDTH*k +: CPU_WIDTH]);
            sel_s2 = sel_s2 | ({CPU_WIDTH{win_oh[k]}} & iReqS2[CPU_WIDTH*k +: CPU_WIDTH]);
        end
    end

    always_comb begin
        and_en = 1'b0;
        or_en  = 1'b0;
        xor_en = 1'b0;
        case (sel_op)
            2'b00:   and_en = 1'b1;
            2'b01:   or_en  = 1'b1;
            2'b10:   xor_en = 1'b1;
            default: ;
        endcase
    end

    assign alu_res = ({CPU_WIDTH{and_en}} & (sel_s1 & sel_s2))
                   | ({CPU_WIDTH{or_en}}  & (sel_s1 | sel_s2))
                   | ({CPU_WIDTH{xor_en}} & (sel_s1 ^ sel_s2));

    always_comb begin
        vld_d  = vld_q;
        rslt_d = rslt_q;
        id_d   = id_q;
        err_d  = err_q;
        ptr_d  = ptr_q;
        if (grant) begin
            vld_d  = 1'b1;
            rslt_d = alu_res;
            id_d   = win_id;
            err_d  = (sel_op == 2'b11);
            ptr_d  = (win_id == ID_W'(REQ_NUM - 1)) ? '0 : win_id + ID_W'(1);
        end else if (vld_q && iRsltRdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            rslt_q <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            rslt_q <= rslt_d;
            id_q   <= id_d;
            err_q  <= err_d;
            ptr_q  <= ptr_d;
        end
    end

    assign oRsltVld = vld_q;
    assign oRslt    = rslt_q;
    assign oRsltId  = id_q;
    assign oRsltErr = err_q;
    assign oBusy    = vld_q;

    logic                          hold_q;
    logic [CPU_WIDTH+ID_W:0]       held_q;

    always_ff @(posedge clk) begin
        hold_q <= !rst & vld_q & !iRsltRdy;
        held_q <= {rslt_q, id_q, err_q};
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(oReqRdy));
            assert ($onehot0({and_en, or_en, xor_en}));
            if (hold_q) assert ({rslt_q, id_q, err_q} == held_q);
        end
    end

endmodule

// File: tb/tb_zion_riscv_isa_lib_bits_ex_arbiter.sv
// Directed bench for the bit-op arbiter: a 3-port RV32 instance and
// a 4-port RV64 instance, each checked against hand-computed values.
module tb_zion_riscv_isa_lib_bits_ex_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  v3, rr3;
    logic [5:0]  op3;
    logic [95:0] s13, s23;
    logic        ov3, rdy3, e3, b3;
    logic [31:0] r3;
    logic [1:0]  id3;

    logic [3:0]   v4, rr4;
    logic [7:0]   op4;
    logic [255:0] s14, s24;
    logic         ov4, rdy4, e4, b4;
    logic [63:0]  r4;
    logic [1:0]   id4;

    int checks = 0;
    int errors = 0;

    zion_riscv_isa_lib_bits_ex_arbiter #(.RV64(0), .REQ_NUM(3)) dut3 (
        .clk(clk), .rst(rst), .iReqVld(v3), .oReqRdy(rr3), .iReqOp(op3),
        .iReqS1(s13), .iReqS2(s23), .oRsltVld(ov3), .iRsltRdy(rdy3),
        .oRslt(r3), .oRsltId(id3), .oRsltErr(e3), .oBusy(b3)
    );

    zion_riscv_isa_lib_bits_ex_arbiter #(.RV64(1), .REQ_NUM(4)) dut4 (
        .clk(clk), .rst(rst), .iReqVld(v4), .oReqRdy(rr4), .iReqOp(op4),
        .iReqS1(s14), .iReqS2(s24), .oRsltVld(ov4), .iRsltRdy(rdy4),
        .oRslt(r4), .oRsltId(id4), .oRsltErr(e4), .oBusy(b4)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp3 [3];

    initial begin
        exp3[0] = 32'h00F0_1200;
        exp3[1] = 32'hFFF0_FF34;
        exp3[2] = 32'hFF00_ED34;

        rst  = 1'b1;
        v3   = 3'b111;
        v4   = 4'b1111;
        rdy3 = 1'b1;
        rdy4 = 1'b1;
        op3  = {2'b10, 2'b01, 2'b00};
        s13  = {3{32'hF0F0_1234}};
        s23  = {3{32'h0FF0_FF00}};
        op4  = {2'b10, 2'b01, 2'b00, 2'b11};
        s14  = {64'hFFFF_0000_0000_FFFF, 64'h0123_4567_89AB_CDEF,
                64'h0, 64'h5};
        s24  = {64'h0000_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111,
                64'h0, 64'h7};

        cyc();
        cyc();
        #1;
        chk("rst_rdy3", 64'(rr3), 64'h0);
        chk("rst_vld3", 64'(ov3), 64'h0);
        chk("rst_rslt3", 64'(r3), 64'h0);
        chk("rst_id3", 64'(id3), 64'h0);
        chk("rst_err3", 64'(e3), 64'h0);
        chk("rst_busy3", 64'(b3), 64'h0);
        chk("rst_rdy4", 64'(rr4), 64'h0);
        chk("rst_vld4", 64'(ov4), 64'h0);

        rst = 1'b0;
        v4  = 4'b0000;
        #1;
        chk("first_grant", 64'(rr3), 64'h1);

        cyc();
        v3 = 3'b001;
        op3[1:0] = 2'b01;
        #1;
        chk("and_vld", 64'(ov3), 64'h1);
        chk("and_rslt", 64'(r3), 64'h00F0_1200);
        chk("and_id", 64'(id3), 64'h0);
        chk("and_err", 64'(e3), 64'h0);
        chk("and_busy", 64'(b3), 64'h1);
        chk("single_grant_a", 64'(rr3), 64'h1);

        cyc();
        op3[1:0] = 2'b10;
        #1;
        chk("or_rslt", 64'(r3), 64'hFFF0_FF34);
        chk("single_grant_b", 64'(rr3), 64'h1);

        cyc();
        op3[1:0] = 2'b11;
        #1;
        chk("xor_rslt", 64'(r3), 64'hFF00_ED34);
        chk("single_grant_c", 64'(rr3), 64'h1);

        cyc();
        v3 = 3'b000;
        #1;
        chk("ill_rslt", 64'(r3), 64'h0);
        chk("ill_err", 64'(e3), 64'h1);
        chk("ill_vld", 64'(ov3), 64'h1);
        chk("idle_grant", 64'(rr3), 64'h0);

        cyc();
        #1;
        chk("drain_vld", 64'(ov3), 64'h0);
        chk("drain_busy", 64'(b3), 64'h0);
        chk("drain_hold_err", 64'(e3), 64'h1);
        v3 = 3'b010;
        op3[1:0] = 2'b00;
        #1;
        chk("p1_grant", 64'(rr3), 64'h2);

        cyc();
        v3   = 3'b000;
        rdy3 = 1'b0;
        #1;
        chk("p1_vld", 64'(ov3), 64'h1);
        chk("p1_id", 64'(id3), 64'h1);
        chk("p1_rslt", 64'(r3), 64'hFFF0_FF34);
        rst = 1'b1;

        cyc();
        #1;
        chk("midrst_vld", 64'(ov3), 64'h0);
        chk("midrst_rslt", 64'(r3), 64'h0);
        chk("midrst_id", 64'(id3), 64'h0);
        rst  = 1'b0;
        v3   = 3'b111;
        rdy3 = 1'b1;
        #1;
        chk("rr_grant0", 64'(rr3), 64'h1);

        for (int i = 1; i < 8; i++) begin
            cyc();
            #1;
            chk("rr_grant", 64'(rr3), 64'(1 << (i % 3)));
            chk("rr_id", 64'(id3), 64'((i - 1) % 3));
            chk("rr_rslt", 64'(r3), 64'(exp3[(i - 1) % 3]));
        end

        cyc();
        rdy3 = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) cyc();
            #1;
            chk("bp_vld", 64'(ov3), 64'h1);
            chk("bp_id", 64'(id3), 64'h1);
            chk("bp_rslt", 64'(r3), 64'hFFF0_FF34);
            chk("bp_nogrant", 64'(rr3), 64'h0);
        end

        cyc();
        rdy3 = 1'b1;
        #1;
        chk("bp_release_grant", 64'(rr3), 64'h4);

        cyc();
        v3 = 3'b000;
        #1;
        chk("bp_next_vld", 64'(ov3), 64'h1);
        chk("bp_next_id", 64'(id3), 64'h2);
        chk("bp_next_rslt", 64'(r3), 64'hFF00_ED34);

        cyc();
        v4 = 4'b1000;
        #1;
        chk("w_grant3", 64'(rr4), 64'h8);

        cyc();
        v4 = 4'b0100;
        #1;
        chk("rv64_vld", 64'(ov4), 64'h1);
        chk("rv64_xor", r4, 64'hFFFF_FFFF_FFFF_0000);
        chk("rv64_id", 64'(id4), 64'h3);
        chk("rv64_err", 64'(e4), 64'h0);
        chk("w_skip_grant2", 64'(rr4), 64'h4);

        cyc();
        v4 = 4'b1111;
        #1;
        chk("w_id2", 64'(id4), 64'h2);
        chk("w_or64", r4, 64'h1133_5577_99BB_DDFF);
        chk("w_ptr3_grant", 64'(rr4), 64'h8);

        cyc();
        #1;
        chk("w_id3", 64'(id4), 64'h3);
        chk("w_wrap_grant", 64'(rr4), 64'h1);

        cyc();
        v4 = 4'b0000;
        #1;
        chk("w_id0", 64'(id4), 64'h0);
        chk("w_ill_err", 64'(e4), 64'h1);
        chk("w_ill_rslt", r4, 64'h0);

        cyc();
        #1;
        chk("w_drain", 64'(ov4), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
